// File: rtl/fetch_pkg.sv
// Fetch stage shared types.
// Bundle handed from fetch to decode, plus FSM states.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_out_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer with flush.
// Push on a full buffer is accepted when a pop happens too.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_q];

  // Pointer and occupancy next state; flush wins.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = bump(wr_q);
      if (pop_ok)  rd_d = bump(rd_q);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    push_i |-> (!full_o || pop_i)
  );

endmodule

// File: rtl/fetch.sv
// RV64 instruction fetch stage.
// Credit-limited in-order reads; redirect flushes and drops in-flight words.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [63:0]  pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  fetch_state_t state_q, state_d;

  logic         discard;
  logic         credit;
  logic [CW:0]  occ;
  logic         req_fire;
  logic         keep;
  logic         pop;

  fetch_out_t    ib_wdata, ib_rdata;
  logic [CW-1:0] ib_cnt;
  logic          ib_full, ib_empty;

  logic [63:0]   pq_rdata;
  logic [CW-1:0] pq_cnt;
  logic          pq_full, pq_empty;

  assign discard = (state_q == FETCH_DRAIN);
  assign occ     = {1'b0, out_q} + {1'b0, ib_cnt};
  assign credit  = (occ < (CW+1)'(FIFO_DEPTH));

  assign imem_req_valid = rst_n && !redirect_valid && credit;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign keep = imem_resp_valid && !discard && !redirect_valid;

  assign instr_valid = !ib_empty && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr       = ib_rdata.instr;
  assign instr_pc    = ib_rdata.pc;

  assign ib_wdata.instr = imem_resp_data;
  assign ib_wdata.pc    = pq_rdata;

  fetch_fifo #(
    .WIDTH ($bits(fetch_out_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (keep),
    .wdata_i (ib_wdata),
    .pop_i   (pop),
    .rdata_o (ib_rdata),
    .count_o (ib_cnt),
    .full_o  (ib_full),
    .empty_o (ib_empty)
  );

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_pcq (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (keep),
    .rdata_o (pq_rdata),
    .count_o (pq_cnt),
    .full_o  (pq_full),
    .empty_o (pq_empty)
  );

  // PC, in-flight and drop counters; redirect overrides.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (req_fire) begin
      pc_d  = pc_q + 64'(INSTR_BYTES);
      out_d = out_d + CW'(1);
    end
    if (imem_resp_valid) out_d = out_d - CW'(1);
    if (redirect_valid) begin
      pc_d   = {redirect_pc[63:2], 2'b00};
      drop_d = out_q - CW'(imem_resp_valid);
    end else if (imem_resp_valid && discard) begin
      drop_d = drop_q - CW'(1);
    end
  end

  // DRAIN while stale responses remain to be dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_RUN:
        if (drop_d != '0) state_d = FETCH_DRAIN;
      FETCH_DRAIN:
        if (drop_d == '0) state_d = FETCH_RUN;
      default: state_d = FETCH_RUN;
    endcase
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      state_q <= FETCH_RUN;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      state_q <= state_d;
    end
  end

  a_resp_expected: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (out_q != '0)
  );

  a_ibuf_room: assert property (
    @(posedge clk) disable iff (!rst_n)
    keep |-> !ib_full
  );

  a_pcq_room: assert property (
    @(posedge clk) disable iff (!rst_n)
    req_fire |-> !pq_full
  );

  a_pcq_has_pc: assert property (
    @(posedge clk) disable iff (!rst_n)
    keep |-> !pq_empty
  );

  a_pcq_balance: assert property (
    @(posedge clk) disable iff (!rst_n)
    ({1'b0, pq_cnt} + {1'b0, drop_q}) == {1'b0, out_q}
  );

endmodule

// File: tb/tb_fetch.sv
// Testbench for the fetch stage.
// Directed cycle tables plus randomized memory/decode vs. a PC-sequence model.
module tb_fetch;

  localparam int          DEPTH = 2;
  localparam logic [63:0] RPC   = 64'h0;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  fetch #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rsp;
    logic [63:0] ra;
    bit          rd;
    logic [63:0] rpc;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_iv;
    logic [63:0] e_ipc;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  vec_t        tv [19];
  mreq_t       memq [$];
  logic [63:0] exp_rpc;
  logic [63:0] exp_ipc;
  int          cyc = 0;
  int          last_due = 0;
  int          n_req = 0;
  int          n_instr = 0;

  function automatic logic [31:0] hash(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'hC0DE_1234;
  endfunction

  function automatic vec_t v(
    input bit rsp, input logic [63:0] ra,
    input bit rd, input logic [63:0] rpc,
    input bit e_req, input logic [63:0] e_addr,
    input bit e_iv, input logic [63:0] e_ipc
  );
    vec_t t;
    t.rsp = rsp;     t.ra = ra;
    t.rd = rd;       t.rpc = rpc;
    t.e_req = e_req; t.e_addr = e_addr;
    t.e_iv = e_iv;   t.e_ipc = e_ipc;
    return t;
  endfunction

  task automatic chk(
    input string nm, input logic [63:0] act, input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    instr_ready = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    memq.delete();
    last_due = 0;
    exp_rpc = RPC;
    exp_ipc = RPC;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_req_addr, RPC);
  endtask

  task automatic apply(input int i);
    vec_t t;
    t = tv[i];
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    imem_resp_valid = t.rsp;
    imem_resp_data = hash(t.ra);
    redirect_valid = t.rd;
    redirect_pc = t.rpc;
    #1;
    chk($sformatf("tv%0d_req_valid", i),
        64'(imem_req_valid), 64'(t.e_req));
    if (t.e_req)
      chk($sformatf("tv%0d_req_addr", i), imem_req_addr, t.e_addr);
    chk($sformatf("tv%0d_instr_valid", i),
        64'(instr_valid), 64'(t.e_iv));
    if (t.e_iv) begin
      chk($sformatf("tv%0d_instr_pc", i), instr_pc, t.e_ipc);
      chk($sformatf("tv%0d_instr", i),
          64'(instr), 64'(hash(t.e_ipc)));
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle of random memory/decode traffic checked against the model.
  task automatic rnd_cycle(
    input int prr, input int pir, input int prd, input int maxlat
  );
    int          occ;
    int          lat;
    logic [63:0] rp;
    occ = memq.size();
    if (occ > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = hash(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < prr);
    instr_ready = ($urandom_range(99) < pir);
    redirect_valid = ($urandom_range(99) < prd);
    rp = {$urandom, $urandom};
    redirect_pc = rp;
    #1;
    if (redirect_valid) begin
      chk("redir_req_valid", 64'(imem_req_valid), 64'd0);
      chk("redir_instr_valid", 64'(instr_valid), 64'd0);
      exp_rpc = {rp[63:2], 2'b00};
      exp_ipc = exp_rpc;
    end else begin
      if (imem_req_valid) begin
        chk("req_addr", imem_req_addr, exp_rpc);
        chk("credit", 64'(occ < DEPTH), 64'd1);
        if (imem_req_ready) begin
          lat = $urandom_range(maxlat, 1);
          last_due = (cyc + lat > last_due + 1) ? cyc + lat
                                                : last_due + 1;
          memq.push_back('{addr: exp_rpc, due: last_due});
          exp_rpc = exp_rpc + 64'd4;
          n_req++;
        end
      end
      if (instr_valid && instr_ready) begin
        chk("instr_pc", instr_pc, exp_ipc);
        chk("instr", 64'(instr), 64'(hash(exp_ipc)));
        exp_ipc = exp_ipc + 64'd4;
        n_instr++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Redirect with two reads in flight to 0x8 / 0xC.
    tv[0]  = v(0, 0,     0, 0,     1, 64'h0,   0, 0);
    tv[1]  = v(1, 64'h0, 0, 0,     1, 64'h4,   0, 0);
    tv[2]  = v(0, 0,     0, 0,     0, 0,       1, 64'h0);
    tv[3]  = v(1, 64'h4, 0, 0,     1, 64'h8,   0, 0);
    tv[4]  = v(0, 0,     0, 0,     0, 0,       1, 64'h4);
    tv[5]  = v(0, 0,     0, 0,     1, 64'hC,   0, 0);
    tv[6]  = v(0, 0,     1, 64'h103, 0, 0,     0, 0);
    tv[7]  = v(1, 64'h8, 0, 0,     0, 0,       0, 0);
    tv[8]  = v(1, 64'hC, 0, 0,     1, 64'h100, 0, 0);
    tv[9]  = v(1, 64'h100, 0, 0,   1, 64'h104, 0, 0);
    tv[10] = v(1, 64'h104, 0, 0,   0, 0,       1, 64'h100);
    tv[11] = v(0, 0,     0, 0,     1, 64'h108, 1, 64'h104);
    // Redirect in the same cycle as a response.
    tv[12] = v(0, 0,     0, 0,     1, 64'h0,   0, 0);
    tv[13] = v(0, 0,     0, 0,     1, 64'h4,   0, 0);
    tv[14] = v(1, 64'h0, 1, 64'h200, 0, 0,     0, 0);
    tv[15] = v(1, 64'h4, 0, 0,     1, 64'h200, 0, 0);
    tv[16] = v(1, 64'h200, 0, 0,   1, 64'h204, 0, 0);
    tv[17] = v(0, 0,     0, 0,     0, 0,       1, 64'h200);
    tv[18] = v(1, 64'h204, 0, 0,   1, 64'h208, 0, 0);

    do_reset();
    for (int i = 0; i < 12; i++) apply(i);
    do_reset();
    for (int i = 12; i < 19; i++) apply(i);

    // Streaming with decode always ready, 1-cycle memory.
    do_reset();
    n_instr = 0;
    repeat (40) rnd_cycle(100, 100, 0, 1);
    chk("stream_rate", 64'(n_instr >= 20), 64'd1);

    // Backpressure: only DEPTH reads before a pop.
    do_reset();
    n_req = 0;
    repeat (12) rnd_cycle(100, 0, 0, 1);
    chk("bp_reqs", 64'(n_req), 64'(DEPTH));
    chk("bp_req_valid_low", 64'(imem_req_valid), 64'd0);
    n_req = 0;
    repeat (4) rnd_cycle(100, 100, 0, 1);
    chk("bp_resume", 64'(n_req > 0), 64'd1);

    // Random traffic, reset mid-stream, more random traffic.
    do_reset();
    repeat (1500) rnd_cycle(75, 70, 3, 5);
    repeat (10) rnd_cycle(100, 0, 0, 2);
    chk("pre_reset_full", 64'(instr_valid), 64'd1);
    do_reset();
    n_instr = 0;
    repeat (1500) rnd_cycle(75, 70, 3, 5);
    chk("progress", 64'(n_instr > 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
